// File: rtl/sa_result_drain_pkg.sv
`default_nettype none
// ============================================================================
// sa_result_drain_pkg : shared systolic-array types and width helpers
// Revision 1.0
// ============================================================================
package sa_result_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } drain_state_e;

  // A product of two BITWIDTH operands needs twice the operand width
  localparam int unsigned RES_WIDTH_MULT = 2;

  function automatic int unsigned res_width(input int unsigned bitwidth);
    return RES_WIDTH_MULT * bitwidth;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sa_drain_buffer.sv
`default_nettype none
// ============================================================================
// sa_drain_buffer : N*N result snapshot with row-select read mux
// Revision 1.0
// ============================================================================
module sa_drain_buffer
  import sa_result_drain_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned EW = 16,
  parameter int unsigned IW = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture,
  input  logic [N*N*EW-1:0] res_in,
  input  logic [IW-1:0]     row_sel,
  output logic [N*EW-1:0]   row_data
);

  localparam int unsigned ROW_W = N * EW;

  logic [N*N*EW-1:0] snap_q;
  logic [N*N*EW-1:0] snap_d;

  always_comb begin
    snap_d = snap_q;
    if (capture) begin
      snap_d = res_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  // Row r of the array occupies a contiguous ROW_W slice of the flat bus
  always_comb begin
    row_data = '0;
    for (int r = 0; r < N; r++) begin
      if (row_sel == IW'(r)) begin
        row_data = snap_q[r*ROW_W +: ROW_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sa_result_drain.sv
`default_nettype none
// ============================================================================
// sa_result_drain : waits for the array result, snapshots it, drains rows
// Revision 1.0
// ============================================================================
module sa_result_drain
  import sa_result_drain_pkg::*;
#(
  parameter int unsigned N              = 4,
  parameter int unsigned BITWIDTH       = 8,
  parameter int unsigned COMPUTE_CYCLES = 3*N-1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  input  logic [N*N*res_width(BITWIDTH)-1:0]     iRes,
  output logic [N*res_width(BITWIDTH)-1:0]       oRowData,
  output logic [idx_width(N)-1:0]                oRowIdx,
  output logic                                   oValid,
  input  logic                                   iReady,
  output logic                                   oLast,
  output logic                                   oBusy,
  output logic                                   oDone
);

  localparam int unsigned EW = res_width(BITWIDTH);
  localparam int unsigned IW = idx_width(N);
  localparam int unsigned CW = (COMPUTE_CYCLES > 0) ? $clog2(COMPUTE_CYCLES + 1) : 1;
  localparam logic [IW-1:0] LAST_ROW   = IW'(N - 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'((COMPUTE_CYCLES > 0) ? COMPUTE_CYCLES - 1 : 0);

  drain_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          capture;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    capture  = 1'b0;
    oValid   = 1'b0;
    oLast    = 1'b0;
    oDone    = 1'b0;
    oBusy    = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          // The counter tracks cycles since start, so the start cycle itself
          // already counts as one; the result is ready at COMPUTE_CYCLES.
          cnt_d   = CW'(1);
          state_d = (COMPUTE_CYCLES <= 1) ? ST_CAPTURE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q >= WAIT_LIMIT) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        ptr_d   = '0;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        oValid = 1'b1;
        oLast  = (ptr_q == LAST_ROW);
        if (iReady) begin
          if (ptr_q == LAST_ROW) begin
            ptr_d   = '0;
            state_d = ST_DONE;
          end else begin
            ptr_d = ptr_q + IW'(1);
          end
        end
      end
      ST_DONE: begin
        oDone   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign oRowIdx = ptr_q;

  sa_drain_buffer #(
    .N  (N),
    .EW (EW),
    .IW (IW)
  ) u_buffer (
    .clk      (clk),
    .reset_n  (reset_n),
    .capture  (capture),
    .res_in   (iRes),
    .row_sel  (ptr_q),
    .row_data (oRowData)
  );

endmodule
`default_nettype wire

// File: tb/tb_sa_result_drain.sv
`default_nettype none
// ============================================================================
// tb_sa_result_drain : directed + randomized bench with a transfer-level model
// Revision 1.0
// ============================================================================
module tb_sa_result_drain;

  localparam int N  = 4;
  localparam int BW = 8;
  localparam int CC = 11;
  localparam int EW = 16;
  localparam int RW = N * N * EW;
  localparam int OW = N * EW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          iReady;
  logic [RW-1:0] iRes;
  logic [OW-1:0] oRowData;
  logic [1:0]    oRowIdx;
  logic          oValid, oLast, oBusy, oDone;

  sa_result_drain #(
    .N              (N),
    .BITWIDTH       (BW),
    .COMPUTE_CYCLES (CC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .iRes     (iRes),
    .oRowData (oRowData),
    .oRowIdx  (oRowIdx),
    .oValid   (oValid),
    .iReady   (iReady),
    .oLast    (oLast),
    .oBusy    (oBusy),
    .oDone    (oDone)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Transfer-level reference: start time, rows handed over, done cycle
  bit            m_active = 1'b0;
  int            m_ts = 0;
  int            m_sent = 0;
  int            m_done = -1;
  logic [OW-1:0] m_snap [N];

  int            q_fv[$];
  int            q_done[$];
  logic          prev_valid = 1'b0;
  logic [OW-1:0] obs_row0 = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] pattern();
    logic [RW-1:0] v;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        v[(r*N+c)*EW +: EW] = 16'(16*r + c);
    return v;
  endfunction

  function automatic logic [RW-1:0] rand_res();
    logic [RW-1:0] v;
    for (int i = 0; i < RW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step(input logic st, input logic rdy, input logic [RW-1:0] res);
    logic exp_valid;
    logic accept;
    @(posedge clk);
    #1;
    start  = st;
    iReady = rdy;
    iRes   = res;
    @(negedge clk);
    exp_valid = m_active && (cyc >= m_ts + CC + 1) && (m_sent < N);
    check("valid", oValid, exp_valid);
    check("busy", oBusy, m_active);
    check("done", oDone, m_active && (cyc == m_done));
    check("last", oLast, exp_valid && (m_sent == N-1));
    if (exp_valid) begin
      check("row_idx", oRowIdx, m_sent[1:0]);
      check("row_data", oRowData, m_snap[m_sent]);
    end
    if (oValid && !prev_valid) begin
      q_fv.push_back(cyc);
      obs_row0 = oRowData;
    end
    if (oDone) q_done.push_back(cyc);
    prev_valid = oValid;
    if (m_active && cyc == m_ts + CC)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          m_snap[r][c*EW +: EW] = res[(r*N+c)*EW +: EW];
    if (exp_valid && rdy) begin
      m_sent++;
      if (m_sent == N) m_done = cyc + 1;
    end
    accept = !m_active && st;
    if (m_active && cyc == m_done) m_active = 1'b0;
    if (accept) begin
      m_active = 1'b1;
      m_ts     = cyc;
      m_sent   = 0;
      m_done   = -1;
    end
    cyc++;
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    start   = 1'b0;
    #1;
    check("rst_valid", oValid, 1'b0);
    check("rst_busy", oBusy, 1'b0);
    check("rst_done", oDone, 1'b0);
    check("rst_last", oLast, 1'b0);
    check("rst_idx", oRowIdx, 2'd0);
    check("rst_data", oRowData, '0);
    m_active   = 1'b0;
    m_sent     = 0;
    m_done     = -1;
    prev_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc++;
  endtask

  task automatic run_case(input int kind, input int ncyc, output int base);
    logic          st, rdy;
    logic [RW-1:0] res;
    base = cyc;
    q_fv.delete();
    q_done.delete();
    for (int rel = 0; rel < ncyc; rel++) begin
      st  = (rel == 0);
      rdy = 1'b1;
      res = pattern();
      case (kind)
        2: rdy = !(rel >= 12 && rel <= 14);
        3: st = (rel == 0) || (rel == 5);
        4: if (rel >= 13) res = '1;
        5: st = (rel == 0) || (rel == 20);
        6: st = (rel == 0) || (rel == 16) || (rel == 17);
        7: begin
          st  = (rel == 0) || (rel < 30 && $urandom_range(0, 7) == 0);
          rdy = (rel >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
          res = rand_res();
        end
        default: ;
      endcase
      if (kind == 5 && rel == 14) reset_cycle();
      else step(st, rdy, res);
    end
    check("idle_end", oBusy, 1'b0);
  endtask

  initial begin
    int base;
    reset_n = 1'b0;
    start   = 1'b0;
    iReady  = 1'b0;
    iRes    = '0;
    #3;
    check("init_valid", oValid, 1'b0);
    check("init_busy", oBusy, 1'b0);
    check("init_done", oDone, 1'b0);
    check("init_last", oLast, 1'b0);
    check("init_idx", oRowIdx, 2'd0);
    check("init_data", oRowData, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Nominal transfer, ready always high
    run_case(1, 22, base);
    check("s1_nfv", q_fv.size(), 1);
    if (q_fv.size() > 0) check("s1_fv_cycle", q_fv[0] - base, 12);
    check("s1_ndone", q_done.size(), 1);
    if (q_done.size() > 0) check("s1_done_cycle", q_done[0] - base, 16);
    check("s1_row0", obs_row0, 64'h0003_0002_0001_0000);

    // Back-pressure on the first three valid cycles
    run_case(2, 26, base);
    if (q_fv.size() > 0) check("s2_fv_cycle", q_fv[0] - base, 12);
    check("s2_ndone", q_done.size(), 1);

    // Spurious start while busy
    run_case(3, 22, base);
    check("s3_nfv", q_fv.size(), 1);
    if (q_fv.size() > 0) check("s3_fv_cycle", q_fv[0] - base, 12);
    if (q_done.size() > 0) check("s3_done_cycle", q_done[0] - base, 16);

    // Input bus changes after the snapshot
    run_case(4, 22, base);
    check("s4_row0", obs_row0, 64'h0003_0002_0001_0000);
    if (q_done.size() > 0) check("s4_done_cycle", q_done[0] - base, 16);

    // Reset during drain, then a fresh start
    run_case(5, 40, base);
    check("s5_ndone", q_done.size(), 1);
    if (q_fv.size() > 0) check("s5_fv_cycle", q_fv[q_fv.size()-1] - base, 32);

    // Start in DONE ignored, start in the following IDLE cycle accepted
    run_case(6, 40, base);
    check("s6_nfv", q_fv.size(), 2);
    if (q_fv.size() > 1 && q_done.size() > 0)
      check("s6_fv_gap", q_fv[1] - (q_done[0] + 1), 12);

    // Randomized data, ready and stray starts
    for (int t = 0; t < 6; t++) run_case(7, 64, base);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
